sqrt_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one sequential square-root unit between NREQ requesters.
- Accepts one operand at a time over per-requester valid/ready and drives the sqrt unit's num/res handshakes.
- Captures the result and returns it to the requester that issued it.
- Sits between client blocks and the single sqrt_sequential instance.

---
 rtl/sqrt_arbiter.sv | 127 ++++++++++++
 tb/tb_sqrt_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/sqrt_arbiter.sv
// sqrt_arbiter: shares one sequential sqrt unit between NREQ requesters.
// Round-robin grant; define SQRT_ARB_FIXED_PRIO_EN for fixed lowest-index priority.
module sqrt_arbiter #(
  parameter  int N    = 16,
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ),
  localparam int RW   = N / 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req_vld,
  output logic [NREQ-1:0]   req_rdy,
  input  logic [NREQ*N-1:0] req_num,
  output logic [NREQ-1:0]   rsp_vld,
  input  logic [NREQ-1:0]   rsp_rdy,
  output logic [RW-1:0]     rsp_res,
  output logic              sq_num_vld,
  input  logic              sq_num_rdy,
  output logic [N-1:0]      sq_num,
  input  logic              sq_res_vld,
  output logic              sq_res_rdy,
  input  logic [RW-1:0]     sq_res,
  output logic              busy,
  output logic [IDW-1:0]    owner
);

  typedef enum logic [1:0] {
    IDLE, ISSUE, WAIT, RETURN
  } state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] owner_q, owner_d;
  logic [N-1:0]   num_q, num_d;
  logic [RW-1:0]  res_q, res_d;
  logic [IDW-1:0] gnt;
  logic           gnt_vld;
  logic [N-1:0]   ops [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_ops
    assign ops[i] = req_num[i*N +: N];
  end

  // Scan downward so the candidate closest to ptr wins.
  always_comb begin : grant_c
    int j;
    logic [IDW-1:0] idx;
    gnt_vld = 1'b0;
    gnt     = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = int'(ptr_q) + k;
      if (j >= NREQ) j = j - NREQ;
      idx = IDW'(j);
      if (req_vld[idx]) begin
        gnt_vld = 1'b1;
        gnt     = idx;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    num_d      = num_q;
    res_d      = res_q;
    req_rdy    = '0;
    rsp_vld    = '0;
    sq_num_vld = 1'b0;
    sq_res_rdy = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          req_rdy[gnt] = 1'b1;
          num_d        = ops[gnt];
          owner_d      = gnt;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        sq_num_vld = 1'b1;
        if (sq_num_rdy) state_d = WAIT;
      end
      WAIT: begin
        sq_res_rdy = 1'b1;
        if (sq_res_vld) begin
          res_d   = sq_res;
          state_d = RETURN;
        end
      end
      RETURN: begin
        rsp_vld[owner_q] = 1'b1;
        if (rsp_rdy[owner_q]) begin
`ifdef SQRT_ARB_FIXED_PRIO_EN
          ptr_d = '0;
`else
          ptr_d = (owner_q == IDW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
`endif
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      num_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      num_q   <= num_d;
      res_q   <= res_d;
    end
  end

  assign sq_num  = num_q;
  assign rsp_res = res_q;
  assign owner   = owner_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_sqrt_arbiter.sv
// tb_sqrt_arbiter: directed bench with a behavioural sqrt unit model.
// Expected results are hand-computed constants.
module tb_sqrt_arbiter;
  localparam int N    = 16;
  localparam int NREQ = 4;

  logic          clk;
  logic          reset_n;
  logic [3:0]    req_vld;
  logic [3:0]    req_rdy;
  logic [63:0]   req_num;
  logic [3:0]    rsp_vld;
  logic [3:0]    rsp_rdy;
  logic [7:0]    rsp_res;
  logic          sq_num_vld;
  logic          sq_num_rdy;
  logic [15:0]   sq_num;
  logic          sq_res_vld;
  logic          sq_res_rdy;
  logic [7:0]    sq_res;
  logic          busy;
  logic [1:0]    owner;

  int total = 0;
  int bad   = 0;

  logic        num_rdy_en;
  logic        m_busy;
  logic [15:0] m_op;
  int          cnt;
  int          hs_cnt = 0;
  logic [15:0] last_num = '0;
  logic [3:0]  cont;
  int          base;

  sqrt_arbiter #(.N(N), .NREQ(NREQ)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_num(req_num),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_res(rsp_res),
    .sq_num_vld(sq_num_vld), .sq_num_rdy(sq_num_rdy), .sq_num(sq_num),
    .sq_res_vld(sq_res_vld), .sq_res_rdy(sq_res_rdy), .sq_res(sq_res),
    .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  assign sq_num_rdy = num_rdy_en & ~m_busy;

  function automatic logic [7:0] isqrt(input logic [15:0] x);
    int r = 0;
    while ((r + 1) * (r + 1) <= int'(x)) r++;
    return 8'(r);
  endfunction

  // Sqrt unit model: three cycles from operand accept to result valid.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_busy     <= 1'b0;
      m_op       <= '0;
      cnt        <= 0;
      sq_res_vld <= 1'b0;
      sq_res     <= '0;
    end else begin
      if (sq_num_vld && sq_num_rdy) begin
        hs_cnt   <= hs_cnt + 1;
        last_num <= sq_num;
      end
      if (sq_res_vld && sq_res_rdy) begin
        sq_res_vld <= 1'b0;
        m_busy     <= 1'b0;
      end else if (m_busy && !sq_res_vld) begin
        if (cnt == 0) begin
          sq_res_vld <= 1'b1;
          sq_res     <= isqrt(m_op);
        end else begin
          cnt <= cnt - 1;
        end
      end else if (!m_busy && sq_num_vld && sq_num_rdy) begin
        m_op   <= sq_num;
        m_busy <= 1'b1;
        cnt    <= 2;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic serve(input int r, input logic [7:0] exp, input string tag);
    int i = 0;
    while (rsp_vld == '0 && i < 100) begin
      @(negedge clk);
      i++;
    end
    chk({tag, "_vld"}, 32'(rsp_vld), 32'(1 << r));
    chk({tag, "_res"}, 32'(rsp_res), 32'(exp));
    chk({tag, "_own"}, 32'(owner), 32'(r));
    rsp_rdy[r] = 1'b1;
    @(posedge clk);
    #1;
    rsp_rdy[r] = 1'b0;
    if (!cont[r]) req_vld[r] = 1'b0;
    @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_reqrdy"}, 32'(req_rdy), 0);
    chk({tag, "_rspvld"}, 32'(rsp_vld), 0);
    chk({tag, "_rspres"}, 32'(rsp_res), 0);
    chk({tag, "_numvld"}, 32'(sq_num_vld), 0);
    chk({tag, "_num"}, 32'(sq_num), 0);
    chk({tag, "_resrdy"}, 32'(sq_res_rdy), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_owner"}, 32'(owner), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clk        = 1'b0;
    reset_n    = 1'b0;
    req_vld    = '0;
    req_num    = '0;
    rsp_rdy    = '0;
    num_rdy_en = 1'b1;
    cont       = '0;
    #12;
    chk_zero("rst");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // single request on requester 2
    req_num[2*16 +: 16] = 16'd144;
    req_vld[2] = 1'b1;
    base = hs_cnt;
    serve(2, 8'd12, "single");
    chk("single_hs", 32'(hs_cnt - base), 1);
    chk("single_num", 32'(last_num), 144);

    // fairness with wrap: ptr is 3 after the single request
    req_num[0*16 +: 16] = 16'd16;
    req_num[3*16 +: 16] = 16'd49;
    cont = 4'b1001;
    req_vld = 4'b1001;
    for (int i = 0; i < 7; i++) begin
      if (i >= 5) cont = '0;
      if (i % 2 == 0) serve(3, 8'd7, "fair3");
      else serve(0, 8'd4, "fair0");
    end

    // simultaneous requests after reset
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    req_num = {16'd49, 16'd36, 16'd25, 16'd16};
    req_vld = 4'hF;
    for (int i = 0; i < 4; i++) serve(i, 8'(4 + i), "simul");

    // backpressure on sqrt unit then on response
    req_num[1*16 +: 16] = 16'hFFFF;
    req_num[0*16 +: 16] = 16'd0;
    num_rdy_en = 1'b0;
    req_vld[1] = 1'b1;
    for (int i = 0; i < 50 && !sq_num_vld; i++) @(negedge clk);
    chk("bp_issue", 32'(sq_num_vld), 1);
    req_vld[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_num", 32'(sq_num), 32'hFFFF);
      chk("bp_reqrdy", 32'(req_rdy), 0);
      chk("bp_numvld", 32'(sq_num_vld), 1);
    end
    num_rdy_en = 1'b1;
    for (int i = 0; i < 50 && rsp_vld == '0; i++) @(negedge clk);
    rsp_rdy = 4'b1101;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_rspvld", 32'(rsp_vld), 32'b0010);
      chk("bp_rspres", 32'(rsp_res), 255);
      chk("bp_reqrdy2", 32'(req_rdy), 0);
    end
    rsp_rdy = '0;
    serve(1, 8'd255, "bp");
    serve(0, 8'd0, "zero");

    // reset during WAIT
    req_num[2*16 +: 16] = 16'd1;
    req_vld[2] = 1'b1;
    for (int i = 0; i < 50 && !sq_res_rdy; i++) @(negedge clk);
    chk("mid_wait", 32'(sq_res_rdy), 1);
    #2;
    reset_n = 1'b0;
    req_vld = '0;
    #1;
    chk_zero("mid");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    req_num[1*16 +: 16] = 16'd65024;
    req_num[3*16 +: 16] = 16'd1;
    req_vld = 4'b1010;
    serve(1, 8'd254, "postrst");
    serve(3, 8'd1, "one");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
